makeup_gain: RTL and testbench
==============================

# makeup_gain

Post-compression make-up gain stage, placed directly downstream of the linear compressor/clipper. It consumes the compressor's Q1.15 sample stream and strobe and multiplies each sample by a programmable unsigned gain. The gain ramps toward its target one step per sample to avoid zipper noise, and the result is rounded and saturated back to Q1.15. The block has a fixed two-stage pipeline and accepts samples on every clock if required.

## Interface
- W_TOTAL, 16: sample width, signed Q1.(W_TOTAL-1).
- W_GAIN, 16: gain width, unsigned.
- GAIN_FRAC, 12: gain fractional bits. Default format is Q4.12, so 0x1000 = 1.0.
- RAMP_STEP, 16'h0010: gain increment/decrement applied per accepted sample.
- i_clk  in  1  single clock; all state changes on the rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_ce  in  1  sample strobe; i_data is valid in this cycle.
- i_data  in  W_TOTAL  signed input sample, normally the compressor's o_data.
- i_gain  in  W_GAIN  unsigned target gain, sampled on each i_ce.
- o_data  out  W_TOTAL  signed gained, rounded and saturated sample.
- o_ce  out  1  one-cycle strobe marking o_data valid.
- o_sat  out  1  high together with o_ce when that sample was saturated.

## Operation
- Reset values:
  - o_data = 0, o_ce = 0, o_sat = 0.
  - Pipeline valid bits cleared.
  - Current gain g_cur = 1.0 (1 << GAIN_FRAC).
- Stage 1, on an i_ce cycle:
  - Register i_data and the applied gain g_app.
  - g_app is g_cur as it was before this edge.
  - Update g_cur at the same edge. Ramp FSM, evaluated per accepted sample only:
    - HOLD (g_cur == i_gain): no change.
    - UP (g_cur < i_gain): g_cur = min(g_cur + RAMP_STEP, i_gain).
    - DOWN (g_cur > i_gain): g_cur = max(g_cur - RAMP_STEP, i_gain).
  - The ramp never overshoots; the last step clamps to the target.
  - No gain change occurs on cycles without i_ce.
- Stage 2:
  - Form the product from i_data (signed) and g_app, zero-extended to signed W_GAIN+1 bits. The product is W_TOTAL+W_GAIN+1 bits wide.
  - Add the rounding term 1 << (GAIN_FRAC-1), then arithmetic-shift right by GAIN_FRAC. This is round-half-up (toward +inf).
  - Saturate to [-2^(W_TOTAL-1), 2^(W_TOTAL-1)-1]. Assert o_sat when clamping occurs.
- Gain 0 produces 0 with o_sat = 0.
- Gain > 1.0 may overflow, which saturates as above.
- i_gain may change at any time. Only its value at an i_ce edge matters.
- Reset mid-operation:
  - In-flight samples are discarded and outputs go to their reset values immediately (asynchronous).
  - g_cur returns to unity.
  - No o_ce is produced for samples accepted before reset.

## Timing
- Latency 2 cycles: an i_ce at edge N yields o_ce high for exactly the one cycle following edge N+2.
- Throughput is one sample per clock. Back-to-back i_ce produces back-to-back o_ce, with order preserved.
- o_data holds its last value while o_ce = 0. o_sat is cleared on any cycle where o_ce = 0.
- There is no backpressure; the downstream consumer must accept every o_ce.

## Configuration
- MAKEUP_GAIN_RAMP_EN:
  - Defined: the ramp FSM is active as described above.
  - Undefined: the FSM and g_cur are removed. g_app = i_gain sampled at the same i_ce, so gain changes take effect on the very next sample. Latency and rounding are unchanged.

## Test plan
- Reset: hold i_reset_n = 0 with i_ce = 1 and i_data = 0xFFFF -> o_data = 0x0000, o_ce = 0, o_sat = 0. After release with i_gain = 0x1000 and input 0x2000 -> o_data = 0x2000, o_ce high 2 cycles later.
- Unity/scale: settled gain 0x2000 (2.0), input 0x3000 -> 0x6000, o_sat = 0.
- Saturation: settled gain 0x4000 (4.0):
  - Input 0x4000 -> 0x7FFF, o_sat = 1.
  - Input 0xC000 -> 0x8000, o_sat = 1.
- Rounding: settled gain 0x0800 (0.5):
  - Input 0x0003 -> 0x0002.
  - Input 0xFFFD -> 0xFFFF.
  - Input 0x0002 -> 0x0001.
- Ramp (macro defined, RAMP_STEP = 0x0100): g_cur = 0x1000, i_gain changed to 0x1400, five samples of input 0x1000 -> outputs 0x1000, 0x1100, 0x1200, 0x1300, 0x1400, then steady at 0x1400. With the macro undefined, the first output is already 0x1400.
- Reset mid-stream: assert reset one cycle after two back-to-back i_ce -> no o_ce is ever emitted for them, and the gain is unity after release.

Source files
------------

// File: rtl/makeup_gain.sv
// makeup_gain: post-compression make-up gain stage.
// Q1.(W_TOTAL-1) samples are multiplied by an unsigned gain with GAIN_FRAC fractional bits.
// The result is rounded half-up and saturated back to W_TOTAL bits.
// Latency is fixed: i_ce at edge N gives o_ce in the cycle after edge N+2.
// Optional feature macro: MAKEUP_GAIN_RAMP_EN. When defined, the applied gain ramps toward
// i_gain by RAMP_STEP per accepted sample. When undefined, i_gain is applied directly.
module makeup_gain #(
  parameter int unsigned W_TOTAL   = 16,
  parameter int unsigned W_GAIN    = 16,
  parameter int unsigned GAIN_FRAC = 12,
  parameter int unsigned RAMP_STEP = 16'h0010
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_ce,
  input  logic [W_TOTAL-1:0] i_data,
  input  logic [W_GAIN-1:0]  i_gain,
  output logic [W_TOTAL-1:0] o_data,
  output logic               o_ce,
  output logic               o_sat
);

  localparam int unsigned WProd = W_TOTAL + W_GAIN + 1;
  localparam logic signed [WProd-1:0] RoundTerm = WProd'(1) << (GAIN_FRAC - 1);
  localparam logic signed [WProd-1:0] SatMax    = WProd'((64'd1 << (W_TOTAL - 1)) - 64'd1);
  localparam logic signed [WProd-1:0] SatMin    = -SatMax - WProd'(1);

  logic [W_GAIN-1:0] g_app;

`ifdef MAKEUP_GAIN_RAMP_EN
  localparam logic [W_GAIN-1:0] Unity = W_GAIN'(1) << GAIN_FRAC;
  localparam logic [W_GAIN-1:0] Step  = W_GAIN'(RAMP_STEP);

  typedef enum logic [1:0] {StHold, StUp, StDown} ramp_e;

  ramp_e             ramp_st;
  logic [W_GAIN-1:0] g_cur_q, g_cur_d;
  logic [W_GAIN:0]   g_up;  // one extra bit so g_cur + step cannot wrap

  // Ramp state register: current gain, unity after reset
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      g_cur_q <= Unity;
    end else begin
      g_cur_q <= g_cur_d;
    end
  end

  // Ramp decision: where the current gain sits relative to the target
  always_comb begin
    ramp_st = StHold;
    if (g_cur_q < i_gain) begin
      ramp_st = StUp;
    end else if (g_cur_q > i_gain) begin
      ramp_st = StDown;
    end
  end

  // Next gain: one clamped step toward the target, only on accepted samples
  always_comb begin
    g_cur_d = g_cur_q;
    g_up    = {1'b0, g_cur_q} + {1'b0, Step};
    if (i_ce) begin
      unique case (ramp_st)
        StUp:    g_cur_d = (g_up >= {1'b0, i_gain}) ? i_gain : g_up[W_GAIN-1:0];
        StDown:  g_cur_d = ((g_cur_q - i_gain) <= Step) ? i_gain : (g_cur_q - Step);
        default: g_cur_d = g_cur_q;
      endcase
    end
  end

  // Applied gain is the value held before this edge
  assign g_app = g_cur_q;
`else
  assign g_app = i_gain;
`endif

  // Stage 1: sample and applied gain
  logic               s1_vld_q, s1_vld_d;
  logic [W_TOTAL-1:0] s1_data_q, s1_data_d;
  logic [W_GAIN-1:0]  s1_gain_q, s1_gain_d;

  always_comb begin
    s1_vld_d  = i_ce;
    s1_data_d = i_ce ? i_data : s1_data_q;
    s1_gain_d = i_ce ? g_app : s1_gain_q;
  end

  // Stage 1 registers
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      s1_vld_q  <= 1'b0;
      s1_data_q <= '0;
      s1_gain_q <= '0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_data_q <= s1_data_d;
      s1_gain_q <= s1_gain_d;
    end
  end

  // Stage 2: full-precision signed product, gain zero-extended to keep it non-negative
  logic                    s2_vld_q, s2_vld_d;
  logic signed [WProd-1:0] s2_prod_q, s2_prod_d;

  always_comb begin
    s2_vld_d  = s1_vld_q;
    s2_prod_d = s1_vld_q ? ($signed(s1_data_q) * $signed({1'b0, s1_gain_q})) : s2_prod_q;
  end

  // Stage 2 registers
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      s2_vld_q  <= 1'b0;
      s2_prod_q <= '0;
    end else begin
      s2_vld_q  <= s2_vld_d;
      s2_prod_q <= s2_prod_d;
    end
  end

  // Round half-up, rescale and saturate to the output range
  logic signed [WProd-1:0] sum;
  logic signed [WProd-1:0] rnd;
  logic                    sat_hi, sat_lo;
  logic [W_TOTAL-1:0]      sat_val;

  always_comb begin
    sum    = s2_prod_q + RoundTerm;
    rnd    = sum >>> GAIN_FRAC;
    sat_hi = (rnd > SatMax);
    sat_lo = (rnd < SatMin);
    if (sat_hi) begin
      sat_val = {1'b0, {(W_TOTAL - 1){1'b1}}};
    end else if (sat_lo) begin
      sat_val = {1'b1, {(W_TOTAL - 1){1'b0}}};
    end else begin
      sat_val = rnd[W_TOTAL-1:0];
    end
  end

  // Output next-state: data holds between strobes, o_sat only alongside o_ce
  logic [W_TOTAL-1:0] o_data_q, o_data_d;
  logic               o_ce_q, o_ce_d;
  logic               o_sat_q, o_sat_d;

  always_comb begin
    o_ce_d   = s2_vld_q;
    o_sat_d  = s2_vld_q & (sat_hi | sat_lo);
    o_data_d = s2_vld_q ? sat_val : o_data_q;
  end

  // Output registers
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_data_q <= '0;
      o_ce_q   <= 1'b0;
      o_sat_q  <= 1'b0;
    end else begin
      o_data_q <= o_data_d;
      o_ce_q   <= o_ce_d;
      o_sat_q  <= o_sat_d;
    end
  end

  assign o_data = o_data_q;
  assign o_ce   = o_ce_q;
  assign o_sat  = o_sat_q;

endmodule

// File: tb/tb_makeup_gain.sv
// Testbench for makeup_gain: directed known-answer steps plus randomized traffic,
// all checked cycle by cycle against an arithmetic reference model.
module tb_makeup_gain;

  localparam int unsigned Step  = 16'h0100;
  localparam int          Unity = 4096;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic        i_ce;
  logic [15:0] i_data;
  logic [15:0] i_gain;
  logic [15:0] o_data;
  logic        o_ce;
  logic        o_sat;

  always #5 i_clk = ~i_clk;

  makeup_gain #(
    .W_TOTAL  (16),
    .W_GAIN   (16),
    .GAIN_FRAC(12),
    .RAMP_STEP(Step)
  ) dut (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_ce     (i_ce),
    .i_data   (i_data),
    .i_gain   (i_gain),
    .o_data   (o_data),
    .o_ce     (o_ce),
    .o_sat    (o_sat)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  int          m_gcur;
  logic        m_vld [3];
  logic [15:0] m_dat [3];
  logic        m_sat [3];
  logic [15:0] m_last;
`ifdef MAKEUP_GAIN_RAMP_EN
  localparam bit RampOn = 1'b1;
`else
  localparam bit RampOn = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Gain-scaled value: round half up (floor of x + 1/2), then clamp to 16-bit signed range
  function automatic void model_out(input logic [15:0] d, input int g,
                                    output logic [15:0] r, output logic s);
    longint p;
    longint q;
    p = longint'($signed(d)) * longint'(g) + 2048;
    if (p >= 0) q = p / 4096;
    else        q = -((-p + 4095) / 4096);
    if (q > 32767) begin
      r = 16'h7FFF; s = 1'b1;
    end else if (q < -32768) begin
      r = 16'h8000; s = 1'b1;
    end else begin
      r = q[15:0];  s = 1'b0;
    end
  endfunction

  task automatic model_reset();
    m_gcur = Unity;
    m_last = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      m_vld[i] = 1'b0; m_dat[i] = 16'h0; m_sat[i] = 1'b0;
    end
  endtask

  task automatic model_edge(input logic ce, input logic [15:0] d, input logic [15:0] g);
    int          gapp;
    logic [15:0] r;
    logic        s;
    m_vld[2] = m_vld[1]; m_dat[2] = m_dat[1]; m_sat[2] = m_sat[1];
    m_vld[1] = m_vld[0]; m_dat[1] = m_dat[0]; m_sat[1] = m_sat[0];
    if (m_vld[2]) m_last = m_dat[2];
    gapp = RampOn ? m_gcur : int'(g);
    model_out(d, gapp, r, s);
    m_vld[0] = ce; m_dat[0] = r; m_sat[0] = s;
    if (ce && RampOn) begin
      if (m_gcur < int'(g))      m_gcur = (m_gcur + int'(Step) > int'(g)) ? int'(g) : m_gcur + int'(Step);
      else if (m_gcur > int'(g)) m_gcur = (m_gcur - int'(Step) < int'(g)) ? int'(g) : m_gcur - int'(Step);
    end
  endtask

  task automatic check_outputs();
    chk("o_ce", o_ce, m_vld[2]);
    chk("o_sat", o_sat, m_vld[2] & m_sat[2]);
    chk("o_data", o_data, m_last);
  endtask

  task automatic cyc(input logic ce, input logic [15:0] d, input logic [15:0] g);
    i_ce = ce; i_data = d; i_gain = g;
    @(posedge i_clk);
    if (i_reset_n) model_edge(ce, d, g);
    #1;
    check_outputs();
  endtask

  task automatic reset_now();
    i_reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
  endtask

  task automatic settle(input logic [15:0] g);
    repeat (64) cyc(1'b1, 16'($urandom), g);
    cyc(1'b0, 16'h0, g);
    cyc(1'b0, 16'h0, g);
  endtask

  task automatic expect_out(input string tag, input logic [15:0] d, input logic [15:0] g,
                            input logic [15:0] exp, input logic exp_sat);
    cyc(1'b1, d, g);
    cyc(1'b0, d, g);
    cyc(1'b0, d, g);
    chk({tag, "_ce"}, o_ce, 1'b1);
    chk({tag, "_data"}, o_data, exp);
    chk({tag, "_sat"}, o_sat, exp_sat);
  endtask

  logic [15:0] cap[$];
  logic [15:0] ramp_exp[6];
  logic [15:0] g_rand;

  initial begin
    i_reset_n = 1'b0; i_ce = 1'b1; i_data = 16'hFFFF; i_gain = 16'h1000;
    model_reset();

    // Reset held with strobe active
    repeat (3) cyc(1'b1, 16'hFFFF, 16'h1000);
    chk("rst_data", o_data, 16'h0000);
    chk("rst_ce", o_ce, 1'b0);
    chk("rst_sat", o_sat, 1'b0);
    i_reset_n = 1'b1;
    expect_out("rst_release", 16'h2000, 16'h1000, 16'h2000, 1'b0);

    // Scale, saturation, rounding, zero gain
    settle(16'h2000);
    expect_out("scale2", 16'h3000, 16'h2000, 16'h6000, 1'b0);
    settle(16'h4000);
    expect_out("sat_pos", 16'h4000, 16'h4000, 16'h7FFF, 1'b1);
    expect_out("sat_neg", 16'hC000, 16'h4000, 16'h8000, 1'b1);
    settle(16'h0800);
    expect_out("rnd_p3", 16'h0003, 16'h0800, 16'h0002, 1'b0);
    expect_out("rnd_m3", 16'hFFFD, 16'h0800, 16'hFFFF, 1'b0);
    expect_out("rnd_p2", 16'h0002, 16'h0800, 16'h0001, 1'b0);
    settle(16'h0000);
    expect_out("gain0", 16'h8000, 16'h0000, 16'h0000, 1'b0);

    // Ramp from unity to 0x1400, back-to-back samples
    settle(16'h1000);
    for (int i = 0; i < 6; i++) ramp_exp[i] = RampOn ? 16'(16'h1000 + 16'h0100 * ((i < 4) ? i : 4)) : 16'h1400;
    for (int i = 0; i < 8; i++) begin
      cyc((i < 6), 16'h1000, 16'h1400);
      if (o_ce) cap.push_back(o_data);
    end
    chk("ramp_count", cap.size(), 6);
    for (int i = 0; i < 6; i++) chk($sformatf("ramp_%0d", i), (i < cap.size()) ? cap[i] : 16'hxxxx, ramp_exp[i]);

    // Reset one cycle after two back-to-back samples
    settle(16'h0800);
    cyc(1'b1, 16'h1234, 16'h0800);
    cyc(1'b1, 16'h2345, 16'h0800);
    reset_now();
    repeat (3) cyc(1'b0, 16'h0, 16'h0800);
    i_reset_n = 1'b1;
    repeat (4) cyc(1'b0, 16'h0, 16'h0800);
    expect_out("unity_after_rst", 16'h2000, 16'h4000,
               RampOn ? 16'h2000 : 16'h7FFF, RampOn ? 1'b0 : 1'b1);

    // Randomized traffic with occasional target changes
    g_rand = 16'h1000;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) g_rand = 16'($urandom_range(0, 16'hFFFF));
      cyc(($urandom_range(0, 3) != 0), 16'($urandom), g_rand);
    end
    repeat (3) cyc(1'b0, 16'h0, g_rand);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
